// File: rtl/dac_spi_dispatch_if.sv
// Sample-stream and serial DAC bus bundle for dac_spi_dispatch.
// master: sample producer / bus observer; slave: the dispatcher itself.
interface dac_spi_dispatch_if #(
   parameter int W_CHAN = 5,
   parameter int W_DIN  = 16
);
   logic              dv_in;
   logic [W_CHAN-1:0] chan_in;
   logic [W_DIN-1:0]  data_in;
   logic              dac_sclk;
   logic              dac_mosi;
   logic              dac_cs_n;
   logic              busy;
   logic              done_out;
   logic [W_CHAN-1:0] done_chan;

   modport master (
      output dv_in, chan_in, data_in,
      input  dac_sclk, dac_mosi, dac_cs_n, busy, done_out, done_chan
   );

   modport slave (
      input  dv_in, chan_in, data_in,
      output dac_sclk, dac_mosi, dac_cs_n, busy, done_out, done_chan
   );
endinterface

// File: rtl/dac_spi_dispatch.sv
// dac_spi_dispatch: takes per-channel samples from the output filter, keeps
// the latest sample per channel, and ships them round-robin to a serial DAC
// as 24-bit frames {4'b0011, chan[3:0], data[15:0]}, MSB first.
// Optional macro DAC_SPI_INIT_EN: after every reset release, send the
// internal-reference-enable word 24'h380001 once before any channel frame.
//
// state | meaning
// IDLE  | no frame in flight; waits for a pending channel (or the init word)
// LOAD  | one cycle: pick channel round-robin, latch frame, clear its pend bit
// INIT  | one cycle: latch the init word (only with DAC_SPI_INIT_EN)
// SHIFT | cs_n low, 24 bits clocked out, CLK_DIV cycles per sclk half-period
// GAP   | cs_n high for CLK_DIV cycles, then done pulse and back to IDLE
module dac_spi_dispatch #(
   parameter int N_CHAN  = 8,
   parameter int W_CHAN  = 5,
   parameter int W_DIN   = 16,
   parameter int CLK_DIV = 4
)(
   input logic              clk_in,
   input logic              rst_in,
   dac_spi_dispatch_if.slave bus
);

   localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
   localparam int W_DIV = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W_DIV-1:0]  DIV_LOAD = W_DIV'(CLK_DIV - 1);
   localparam logic [W_CHAN:0]   N_CHAN_W = (W_CHAN + 1)'(N_CHAN);
   localparam logic [W_IDX-1:0]  LAST_RST = W_IDX'(N_CHAN - 1);
`ifdef DAC_SPI_INIT_EN
   localparam logic [23:0]       INIT_WORD = 24'h380001;
`endif

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
`ifdef DAC_SPI_INIT_EN
      , INIT
`endif
   } state_t;

   state_t             state;
   logic               dv_q;
   logic [W_CHAN-1:0]  chan_q;
   logic [W_DIN-1:0]   data_q;
   logic [N_CHAN-1:0]  pend;
   logic [W_IDX-1:0]   last_served;
   logic [W_IDX-1:0]   sel;
   logic [W_IDX-1:0]   rr_sel;
   logic [22:0]        shift_reg;
   logic [4:0]         bit_cnt;
   logic [W_DIV-1:0]   div_cnt;
   logic [23:0]        frame_word;
   logic               sclk_q;
   logic               mosi_q;
   logic               cs_n_q;
   logic               done_q;
   logic [W_CHAN-1:0]  done_chan_q;
   logic               wr_en;
   logic [W_IDX-1:0]   wr_idx;
   logic [W_DIN-1:0]   data_mem [N_CHAN];
`ifdef DAC_SPI_INIT_EN
   logic               init_pend;
   logic               is_init;
`endif

   // Samples are registered once so dv_in never competes with the arbiter
   // in the same cycle; out-of-range channels are simply dropped.
   assign wr_en  = dv_q && ({1'b0, chan_q} < N_CHAN_W);
   assign wr_idx = chan_q[W_IDX-1:0];

   assign bus.dac_sclk  = sclk_q;
   assign bus.dac_mosi  = mosi_q;
   assign bus.dac_cs_n  = cs_n_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done_out  = done_q;
   assign bus.done_chan = done_chan_q;

   // Round-robin pick: first pending channel after the one served last.
   always_comb begin
      logic found;
      int   idx;
      found  = 1'b0;
      idx    = 0;
      rr_sel = last_served;
      for (int i = 1; i <= N_CHAN; i++) begin
         idx = (int'(last_served) + i) % N_CHAN;
         if (!found && pend[W_IDX'(idx)]) begin
            found  = 1'b1;
            rr_sel = W_IDX'(idx);
         end
      end
   end

   // Word to be latched on the LOAD (or INIT) cycle.
   always_comb begin
      frame_word = {4'b0011, 4'(rr_sel), data_mem[rr_sel]};
`ifdef DAC_SPI_INIT_EN
      if (state == INIT) frame_word = INIT_WORD;
`endif
   end

   // Sample store; deliberately not reset so data survives a reset.
   always_ff @(posedge clk_in) begin
      if (wr_en) data_mem[wr_idx] <= data_q;
   end

   // Frame sequencer with registered serial outputs and pend bookkeeping.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= IDLE;
         dv_q        <= 1'b0;
         chan_q      <= '0;
         data_q      <= '0;
         pend        <= '0;
         last_served <= LAST_RST;
         sel         <= '0;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         done_q      <= 1'b0;
         done_chan_q <= '0;
`ifdef DAC_SPI_INIT_EN
         init_pend   <= 1'b1;
         is_init     <= 1'b0;
`endif
      end else begin
         dv_q   <= bus.dv_in;
         chan_q <= bus.chan_in;
         data_q <= bus.data_in;
         done_q <= 1'b0;

         case (state)
            IDLE: begin
`ifdef DAC_SPI_INIT_EN
               if (init_pend)  state <= INIT;
               else
`endif
               if (|pend)      state <= LOAD;
            end

            LOAD: begin
               sel               <= rr_sel;
               last_served       <= rr_sel;
               pend[rr_sel]      <= 1'b0;
`ifdef DAC_SPI_INIT_EN
               is_init           <= 1'b0;
`endif
               cs_n_q            <= 1'b0;
               sclk_q            <= 1'b1;
               mosi_q            <= frame_word[23];
               shift_reg         <= frame_word[22:0];
               bit_cnt           <= 5'd23;
               div_cnt           <= DIV_LOAD;
               state             <= SHIFT;
            end

`ifdef DAC_SPI_INIT_EN
            INIT: begin
               init_pend         <= 1'b0;
               is_init           <= 1'b1;
               cs_n_q            <= 1'b0;
               sclk_q            <= 1'b1;
               mosi_q            <= frame_word[23];
               shift_reg         <= frame_word[22:0];
               bit_cnt           <= 5'd23;
               div_cnt           <= DIV_LOAD;
               state             <= SHIFT;
            end
`endif

            SHIFT: begin
               if (div_cnt != '0) begin
                  div_cnt <= div_cnt - 1'b1;
               end else begin
                  div_cnt <= DIV_LOAD;
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                  end else if (bit_cnt == 5'd0) begin
                     cs_n_q <= 1'b1;
                     state  <= GAP;
                  end else begin
                     bit_cnt   <= bit_cnt - 1'b1;
                     sclk_q    <= 1'b1;
                     mosi_q    <= shift_reg[22];
                     shift_reg <= {shift_reg[21:0], 1'b0};
                  end
               end
            end

            GAP: begin
               if (div_cnt != '0) begin
                  div_cnt <= div_cnt - 1'b1;
               end else begin
                  state <= IDLE;
`ifdef DAC_SPI_INIT_EN
                  if (!is_init) begin
                     done_q      <= 1'b1;
                     done_chan_q <= W_CHAN'(sel);
                  end
`else
                  done_q      <= 1'b1;
                  done_chan_q <= W_CHAN'(sel);
`endif
               end
            end

            default: state <= IDLE;
         endcase

         // A sample landing on the LOAD cycle must survive the clear above.
         if (wr_en) pend[wr_idx] <= 1'b1;
      end
   end

endmodule

// File: doc/dac_spi_dispatch.md
DAC_SPI_DISPATCH -- requirements
Module: dac_spi_dispatch

Interface
REQ-001 SHALL have parameter N_CHAN, default 8, number of DAC channels.
REQ-002 SHALL have parameter W_CHAN, default 5, channel index width.
REQ-003 SHALL have parameter W_DIN, default 16, input data width, equal to the DAC word width.
REQ-004 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk_in cycles, minimum 1.
REQ-005 SHALL have port clk_in, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports dv_in (input, 1), chan_in (input, W_CHAN) and data_in (input, W_DIN), the output-filter sample stream.
REQ-008 SHALL have ports dac_sclk, dac_mosi and dac_cs_n, outputs, 1 bit each, forming the serial DAC bus.
REQ-009 SHALL have ports busy (output, 1), done_out (output, 1) and done_chan (output, W_CHAN), for frame status.

Function
REQ-010 SHALL register a sample when dv_in=1 and chan_in<N_CHAN, storing data_in into data_mem[chan_in] and setting pend[chan_in].
REQ-011 SHALL ignore dv_in when chan_in>=N_CHAN; no state change.
REQ-012 SHALL apply latest-wins: a new sample for a channel with pend already set overwrites data_mem and raises no error.
REQ-013 SHALL implement the FSM IDLE -> LOAD -> SHIFT -> GAP -> IDLE.
REQ-014 SHALL, in IDLE with any pend bit set, select a channel round-robin starting at (last_served+1) mod N_CHAN, and move to LOAD.
REQ-015 SHALL, in LOAD (one cycle), latch frame = {4'b0011, chan[3:0], data_mem[chan][15:0]} (24 bits, MSB first) and clear pend[chan].
REQ-016 SHALL keep pend[chan] set if a dv_in for the same chan arrives on the LOAD cycle, with the new data.
REQ-017 SHALL, in SHIFT, hold dac_cs_n=0 and present 24 bits. Each bit: dac_sclk high for CLK_DIV cycles, then low for CLK_DIV cycles. dac_mosi changes only at the sclk rising edge; the DAC samples on the falling edge.
REQ-018 SHALL make SHIFT last exactly 48*CLK_DIV cycles, then move to GAP with dac_cs_n=1 and dac_sclk=0.
REQ-019 SHALL hold GAP for CLK_DIV cycles, then pulse done_out=1 for one cycle with done_chan=chan and return to IDLE.
REQ-020 SHALL make frames immutable once latched: dv_in for the in-flight channel during SHIFT or GAP only updates data_mem and pend.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL meet this latency from idle: dv_in sampled at edge k, LOAD at k+2, dac_cs_n falls at k+3.
REQ-023 SHALL require no backpressure: dv_in is accepted every cycle, and pending state is bounded at one entry per channel.

Reset
REQ-024 SHALL, while rst_in=0, asynchronously force: FSM=IDLE, pend=0, last_served=N_CHAN-1, dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, done_out=0, done_chan=0.
REQ-025 SHALL leave data_mem unchanged by reset.
REQ-026 SHALL, on reset mid-frame, deassert dac_cs_n immediately; no done_out is produced for the aborted frame.
REQ-027 SHALL, after rst_in rises, accept dv_in from the first clock edge onward.

Configuration
REQ-028 SHALL provide macro DAC_SPI_INIT_EN; when defined, the block sends 24'h380001 (internal reference enable) exactly once after each reset release, ahead of any channel frame.
REQ-029 SHALL send the init frame with the same SHIFT/GAP timing as channel frames, via an INIT state entered from IDLE with priority over pend. The init frame produces done_out=0, and samples received meanwhile are queued.
REQ-030 SHALL, when DAC_SPI_INIT_EN is not defined, omit the INIT state entirely; the first frame after reset is a channel frame.

Verification
REQ-031 SHALL cover: CLK_DIV=4, dv_in chan=2 data=16'hABCD -> cs_n low 192 cycles, MOSI=24'h32ABCD, done_out with done_chan=2.
REQ-032 SHALL cover: dv_in chan 5 and chan 1 on consecutive cycles from reset -> frames for chan 1 then chan 5 (round-robin from 0).
REQ-033 SHALL cover: three dv_in to chan 3 (0x0001, 0x0002, 0x0003) during another channel's frame -> exactly one chan-3 frame carrying 0x0003.
REQ-034 SHALL cover: dv_in chan=9 with N_CHAN=8 -> no frame, busy stays 0.
REQ-035 SHALL cover: rst_in low at SCLK edge 10 of a frame -> cs_n=1 at once, no done_out, and a fresh frame after the next dv_in.
REQ-036 SHALL cover: with DAC_SPI_INIT_EN, reset release and dv_in chan 0 at the same time -> 24'h380001 frame, then the chan-0 frame.
